// File: rtl/uart_tx_frame.sv
// uart_tx_frame: byte-serial UART transmitter, 1 start, 8 data (LSB first),
// 1 stop bit, with bit timing from an internal divider on clk.
//
// Core handshake: a byte is accepted on a rising clk edge where
// tx_valid && tx_ready. tx_ready is high only in IDLE. tx_data is sampled
// only on that edge. tx_valid seen while busy is ignored.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (11-bit frame).
module uart_tx_frame #(
  parameter int CLKRATE  = 50_000_000,
  parameter int BAUDRATE = 9600
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int BAUDDIV = CLKRATE / BAUDRATE;
  localparam int CW      = (BAUDDIV < 2) ? 1 : $clog2(BAUDDIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUDDIV - 1);

  // A divider below 2 cannot hold a bit for a whole number of cycles.
  if (BAUDDIV < 2) begin : g_baud_check
    $error("uart_tx_frame: CLKRATE/BAUDRATE must be at least 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  logic baud_last;
  // End of the current bit period.
  assign baud_last = (baud_cnt == BAUD_LAST);

  // Frame sequencer: state, baud divider, shift register and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      // The divider only runs while a frame is on the line; it is 0 in IDLE.
      if (state != IDLE) begin
        baud_cnt <= baud_last ? '0 : baud_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift    <= tx_data;
            txd      <= 1'b0;
            state    <= START;
            baud_cnt <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity   <= ^tx_data;
`endif
          end
        end

        START: begin
          if (baud_last) begin
            txd     <= shift[0];
            state   <= DATA;
            bit_idx <= 3'd0;
          end
        end

        DATA: begin
          if (baud_last) begin
            if (bit_idx != 3'd7) begin
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end else begin
`ifdef UART_TX_PARITY_EN
              txd   <= parity;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            txd   <= 1'b1;
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (baud_last) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame at CLKRATE=8,
// BAUDRATE=1 (8 clk cycles per bit). Expected frames are hand-written bit
// patterns, bit k = k-th bit on the line (start first, stop last).
// Inputs change on the falling edge or 1 ns after the rising edge;
// outputs are sampled on the falling edge.
module tb_uart_tx_frame;

  localparam int BAUDDIV = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [10:0] F_A5 = 11'b1_0_10100101_0;
  localparam logic [10:0] F_07 = 11'b1_1_00000111_0;
  localparam logic [10:0] F_01 = 11'b1_1_00000001_0;
  localparam logic [10:0] F_5A = 11'b1_0_01011010_0;
  localparam logic [10:0] F_00 = 11'b1_0_00000000_0;
  localparam logic [10:0] F_FF = 11'b1_0_11111111_0;
  localparam logic [10:0] F_3C = 11'b1_0_00111100_0;
  localparam logic [10:0] F_55 = 11'b1_0_01010101_0;
`else
  localparam int NBITS = 10;
  localparam logic [10:0] F_A5 = 11'b0_1_10100101_0;
  localparam logic [10:0] F_07 = 11'b0_1_00000111_0;
  localparam logic [10:0] F_01 = 11'b0_1_00000001_0;
  localparam logic [10:0] F_5A = 11'b0_1_01011010_0;
  localparam logic [10:0] F_00 = 11'b0_1_00000000_0;
  localparam logic [10:0] F_FF = 11'b0_1_11111111_0;
  localparam logic [10:0] F_3C = 11'b0_1_00111100_0;
  localparam logic [10:0] F_55 = 11'b0_1_01010101_0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  logic       clk;
  logic       nrst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;

  int n_tests;
  int n_fail;

  vec_t vecs[4];

  uart_tx_frame #(
    .CLKRATE (8),
    .BAUDRATE(1)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd     (txd),
    .busy    (busy)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, and reports any failure.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line idle for n cycles: txd high, ready high, not busy.
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_txd", txd, 1);
      check("idle_ready", tx_ready, 1);
      check("idle_busy", busy, 0);
    end
  endtask

  // Present one byte for exactly one rising edge, then scramble tx_data.
  task automatic accept(input logic [7:0] d);
    check("accept_ready", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = ~d;
  endtask

  // Walk a whole frame starting just after its acceptance edge. A glitch
  // index >= 0 pulses tx_valid with 0x81 for one cycle at that frame cycle.
  task automatic check_body(input logic [10:0] exp, input int glitch);
    for (int i = 0; i < NBITS * BAUDDIV; i++) begin
      @(negedge clk);
      if (i == glitch) begin
        tx_valid = 1'b1;
        tx_data  = 8'h81;
      end
      if (glitch >= 0 && i == glitch + 1) begin
        tx_valid = 1'b0;
      end
      check("frame_txd", txd, exp[i / BAUDDIV]);
      check("frame_ready", tx_ready, 0);
      check("frame_busy", busy, 1);
    end
    @(negedge clk);
    check("end_ready", tx_ready, 1);
    check("end_busy", busy, 0);
    check("end_txd", txd, 1);
  endtask

  initial begin
    logic [10:0] f55;
    n_tests  = 0;
    n_fail   = 0;
    nrst     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    vecs[0] = '{data: 8'hA5, frame: F_A5};
    vecs[1] = '{data: 8'h07, frame: F_07};
    vecs[2] = '{data: 8'h01, frame: F_01};
    vecs[3] = '{data: 8'h5A, frame: F_5A};

    // Reset idle.
    repeat (5) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    nrst = 1'b1;
    idle_check(20);

    // Single frames from the vector table.
    foreach (vecs[k]) begin
      accept(vecs[k].data);
      check_body(vecs[k].frame, -1);
    end

    // Back-to-back 0x00 then 0xFF with tx_valid held high: the second byte
    // is taken on the first edge that sees tx_ready high again.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'hFF;
    check_body(F_00, -1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    check_body(F_FF, -1);

    // tx_valid while busy is ignored; no second frame follows.
    accept(8'h3C);
    check_body(F_3C, 30);
    idle_check(20);

    // Reset mid-frame: line returns high at once, nothing retained.
    f55 = F_55;
    accept(8'h55);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("pre_rst_txd", txd, f55[i / BAUDDIV]);
    end
    #2;
    nrst = 1'b0;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_ready", tx_ready, 1);
    check("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    idle_check(20);

    // A fresh frame after the abandoned one is clean.
    accept(8'hA5);
    check_body(F_A5, -1);
    idle_check(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
